auth_engine: RTL and testbench

Sequential, parametrised account authenticator for the ATM datapath. It holds the account/PIN database and a per-account failed-attempt counter with lockout. It serves AUTH, CHANGE_PIN and UNLOCK requests through a valid/ready request port and a single-cycle response pulse. It sits between the card/keypad front end and the transaction controller, which consumes the status and account index.

---
 rtl/auth_pkg.sv | 49 ++++
 rtl/auth_db.sv | 63 ++++++
 rtl/auth_engine.sv | 177 +++++++++++++++++
 tb/tb_auth_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// ---------------------------------------------------------------------------
// auth_pkg
// Shared types and constants for the ATM account authenticator:
//   op_t     - request opcodes (an opcode value of 3 is handled like OP_AUTH)
//   stat_t   - response status codes
//   state_t  - authenticator FSM states
//   DEFAULT_PINS / default_pin() - PIN loaded into each database entry at reset
// ---------------------------------------------------------------------------
package auth_pkg;

    typedef enum logic [1:0] {
        OP_AUTH       = 2'd0,
        OP_CHANGE_PIN = 2'd1,
        OP_UNLOCK     = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        STAT_AUTH_OK     = 3'd0,
        STAT_NOT_FOUND   = 3'd1,
        STAT_BAD_PIN     = 3'd2,
        STAT_LOCKED      = 3'd3,
        STAT_PIN_CHANGED = 3'd4,
        STAT_PIN_SAME    = 3'd5,
        STAT_UNLOCKED    = 3'd6
    } stat_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_CHECK  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int DEFAULT_PIN_COUNT = 10;

    localparam logic [15:0] DEFAULT_PINS [DEFAULT_PIN_COUNT] = '{
        16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
        16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123
    };

    // Entries beyond the fixed table get a PIN derived from their index.
    function automatic logic [15:0] default_pin(input int i);
        if (i < DEFAULT_PIN_COUNT) begin
            return DEFAULT_PINS[i[3:0]];
        end
        return 16'(1000 + i);
    endfunction

endpackage

// File: rtl/auth_db.sv
// ---------------------------------------------------------------------------
// auth_db
// Account database: per entry an account number, a PIN and a failed-attempt
// counter. All contents are reloaded by the synchronous reset.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rd_idx                combinational read index
//   rd_acc, rd_pin, rd_cnt  contents of entry rd_idx
//   wr_idx                write index
//   pin_we, wr_pin        PIN write enable / data
//   cnt_we, wr_cnt        counter write enable / data
// ---------------------------------------------------------------------------
module auth_db
    import auth_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 4,
    parameter int PIN_W        = 16,
    parameter int IDX_W        = 4,
    parameter int CNT_W        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ACC_W-1:0] rd_acc,
    output logic [PIN_W-1:0] rd_pin,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             pin_we,
    input  logic [PIN_W-1:0] wr_pin,
    input  logic             cnt_we,
    input  logic [CNT_W-1:0] wr_cnt
);

    logic [ACC_W-1:0] acc_mem [NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin_mem [NUM_ACCOUNTS];
    logic [CNT_W-1:0] cnt_mem [NUM_ACCOUNTS];

    // Reset loads entry i with account i+1 and its default PIN, and clears
    // every counter. Reset takes priority, so a write pending on the same
    // edge is dropped. Account numbers are never rewritten after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                acc_mem[i] <= ACC_W'(i + 1);
                pin_mem[i] <= PIN_W'(default_pin(i));
                cnt_mem[i] <= '0;
            end
        end else begin
            if (pin_we) begin
                pin_mem[wr_idx] <= wr_pin;
            end
            if (cnt_we) begin
                cnt_mem[wr_idx] <= wr_cnt;
            end
        end
    end

    assign rd_acc = acc_mem[rd_idx];
    assign rd_pin = pin_mem[rd_idx];
    assign rd_cnt = cnt_mem[rd_idx];

endmodule

// File: rtl/auth_engine.sv
// ---------------------------------------------------------------------------
// auth_engine
// Sequential account authenticator. A request is captured at accept, the
// database is searched linearly one entry per cycle, the matched entry is
// checked (lockout, PIN compare, PIN change) and a one-cycle response strobe
// carries the status and matched index.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid, req_ready          request handshake (accept = both high)
//   req_op, acc_num, pin, new_pin request fields, captured at accept
//   rsp_valid                     one-cycle response strobe
//   rsp_status, rsp_index         status code and matched index (held)
//   busy                          inverse of req_ready
// ---------------------------------------------------------------------------
module auth_engine
    import auth_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 4,
    parameter int PIN_W        = 16,
    parameter int MAX_TRIES    = 3,
    parameter int IDX_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] new_pin,
    output logic             rsp_valid,
    output logic [2:0]       rsp_status,
    output logic [IDX_W-1:0] rsp_index,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       op_q;
    logic [ACC_W-1:0] acc_q;
    logic [PIN_W-1:0] pin_q;
    logic [PIN_W-1:0] new_pin_q;

    logic [ACC_W-1:0] rd_acc;
    logic [PIN_W-1:0] rd_pin;
    logic [CNT_W-1:0] rd_cnt;

    logic             entry_match;
    stat_t            chk_status;
    logic             pin_we;
    logic             cnt_we;
    logic [CNT_W-1:0] wr_cnt;

    auth_db #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .ACC_W        (ACC_W),
        .PIN_W        (PIN_W),
        .IDX_W        (IDX_W),
        .CNT_W        (CNT_W)
    ) u_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (idx),
        .rd_acc (rd_acc),
        .rd_pin (rd_pin),
        .rd_cnt (rd_cnt),
        .wr_idx (idx),
        .pin_we (pin_we),
        .wr_pin (new_pin_q),
        .cnt_we (cnt_we),
        .wr_cnt (wr_cnt)
    );

    // Account 0 is reserved and must never match, even if an entry's
    // account number wraps to zero in a narrow ACC_W.
    assign entry_match = (acc_q != '0) && (rd_acc == acc_q);

    // Decision for the matched entry, walked in priority order: unlock,
    // lockout, PIN compare, then the operation itself. Writes are only
    // enabled in CHECK so the database updates on the CHECK->RESP edge.
    always_comb begin
        chk_status = STAT_AUTH_OK;
        pin_we     = 1'b0;
        cnt_we     = 1'b0;
        wr_cnt     = '0;
        if (state == S_CHECK) begin
            if (op_q == OP_UNLOCK) begin
                cnt_we     = 1'b1;
                chk_status = STAT_UNLOCKED;
            end else if (rd_cnt == CNT_MAX) begin
                chk_status = STAT_LOCKED;
            end else if (pin_q != rd_pin) begin
                cnt_we     = 1'b1;
                wr_cnt     = (rd_cnt >= CNT_MAX) ? CNT_MAX : CNT_W'(rd_cnt + 1'b1);
                chk_status = STAT_BAD_PIN;
            end else if (op_q == OP_CHANGE_PIN) begin
                cnt_we = 1'b1;
                if (new_pin_q == rd_pin) begin
                    chk_status = STAT_PIN_SAME;
                end else begin
                    pin_we     = 1'b1;
                    chk_status = STAT_PIN_CHANGED;
                end
            end else begin
                cnt_we     = 1'b1;
                chk_status = STAT_AUTH_OK;
            end
        end
    end

    // Request FSM with registered handshake and response outputs. The
    // response fields only change when a response is launched, so they
    // hold their last value while idle; rsp_valid defaults low so it is a
    // single-cycle strobe. Not-found skips CHECK and responds directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            pin_q      <= '0;
            new_pin_q  <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= STAT_NOT_FOUND;
            rsp_index  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        acc_q     <= acc_num;
                        pin_q     <= pin;
                        new_pin_q <= new_pin;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (entry_match) begin
                        state <= S_CHECK;
                    end else if (idx == LAST_IDX) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= STAT_NOT_FOUND;
                        rsp_index  <= '0;
                        state      <= S_RESP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_CHECK: begin
                    rsp_valid  <= 1'b1;
                    rsp_status <= chk_status;
                    rsp_index  <= idx;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = ~req_ready;

endmodule

// File: tb/tb_auth_engine.sv
// ---------------------------------------------------------------------------
// tb_auth_engine
// Directed bench for auth_engine. Instance a uses the default 10-entry
// database, instance b a 16-entry database with 5-bit account numbers.
// Request fields are shared; each instance has its own req_valid.
// ---------------------------------------------------------------------------
module tb_auth_engine;

    logic        clk;
    logic        rst_n;
    logic        req_valid_a;
    logic        req_valid_b;
    logic [1:0]  req_op;
    logic [4:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;

    logic        req_ready_a, rsp_valid_a, busy_a;
    logic [2:0]  rsp_status_a;
    logic [3:0]  rsp_index_a;
    logic        req_ready_b, rsp_valid_b, busy_b;
    logic [2:0]  rsp_status_b;
    logic [3:0]  rsp_index_b;

    int tests_run    = 0;
    int tests_failed = 0;

    auth_engine dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_a),
        .req_ready  (req_ready_a),
        .req_op     (req_op),
        .acc_num    (acc_num[3:0]),
        .pin        (pin),
        .new_pin    (new_pin),
        .rsp_valid  (rsp_valid_a),
        .rsp_status (rsp_status_a),
        .rsp_index  (rsp_index_a),
        .busy       (busy_a)
    );

    auth_engine #(
        .NUM_ACCOUNTS (16),
        .ACC_W        (5)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_op     (req_op),
        .acc_num    (acc_num),
        .pin        (pin),
        .new_pin    (new_pin),
        .rsp_valid  (rsp_valid_b),
        .rsp_status (rsp_status_b),
        .rsp_index  (rsp_index_b),
        .busy       (busy_b)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
        end
    endtask

    // Issues one request, scrambles the inputs right after accept, waits a
    // bounded number of cycles for the response and checks latency (in
    // cycles counted from the accept cycle T), status, index, that req_ready
    // stayed low and that it returns high one cycle after the response.
    task automatic applyStimulus(input string tag, input bit use_b,
                                 input logic [1:0] op, input logic [4:0] acc,
                                 input logic [15:0] p, input logic [15:0] np,
                                 input int exp_lat, input logic [2:0] exp_stat,
                                 input logic [3:0] exp_idx);
        int  cyc;
        bit  ready_seen;
        bit  got;
        @(negedge clk);
        req_op  = op;
        acc_num = acc;
        pin     = p;
        new_pin = np;
        if (use_b) req_valid_b = 1'b1;
        else       req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_op      = 2'd2;
        acc_num     = 5'd7;
        pin         = 16'hFFFF;
        new_pin     = 16'hAAAA;
        cyc        = 1;
        ready_seen = 1'b0;
        got        = use_b ? rsp_valid_b : rsp_valid_a;
        while (!got && cyc < 40) begin
            if (use_b ? req_ready_b : req_ready_a) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            got = use_b ? rsp_valid_b : rsp_valid_a;
        end
        if (use_b ? req_ready_b : req_ready_a) ready_seen = 1'b1;
        checkOutput({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        checkOutput({tag, " status"}, use_b ? rsp_status_b : rsp_status_a, exp_stat);
        checkOutput({tag, " index"}, use_b ? rsp_index_b : rsp_index_a, exp_idx);
        checkOutput({tag, " ready low while busy"}, ready_seen, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, " ready after resp"}, use_b ? req_ready_b : req_ready_a, 1);
        checkOutput({tag, " strobe one cycle"}, use_b ? rsp_valid_b : rsp_valid_a, 0);
    endtask

    // Directed sequence: expected latencies are 3+k for a match at index k
    // and NUM_ACCOUNTS+1 for not-found.
    initial begin
        bit seen_rsp;
        rst_n       = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_op      = 2'd0;
        acc_num     = '0;
        pin         = '0;
        new_pin     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("reset req_ready", req_ready_a, 1);
        checkOutput("reset busy", busy_a, 0);
        checkOutput("reset rsp_valid", rsp_valid_a, 0);
        checkOutput("reset rsp_status", rsp_status_a, 1);
        checkOutput("reset rsp_index", rsp_index_a, 0);
        checkOutput("reset b req_ready", req_ready_b, 1);

        applyStimulus("auth acc3",      0, 2'd0, 5'd3,  16'd3456, 16'd0, 5,  3'd0, 4'd2);
        checkOutput("held status after resp", rsp_status_a, 0);
        applyStimulus("auth acc12",     0, 2'd0, 5'd12, 16'd1234, 16'd0, 11, 3'd1, 4'd0);
        applyStimulus("auth acc0",      0, 2'd0, 5'd0,  16'd1234, 16'd0, 11, 3'd1, 4'd0);
        applyStimulus("op3 as auth",    0, 2'd3, 5'd4,  16'd4567, 16'd0, 6,  3'd0, 4'd3);

        applyStimulus("bad pin 1",      0, 2'd0, 5'd1,  16'd1111, 16'd0, 3,  3'd2, 4'd0);
        applyStimulus("bad pin 2",      0, 2'd0, 5'd1,  16'd1111, 16'd0, 3,  3'd2, 4'd0);
        applyStimulus("bad pin 3",      0, 2'd0, 5'd1,  16'd1111, 16'd0, 3,  3'd2, 4'd0);
        applyStimulus("locked",         0, 2'd0, 5'd1,  16'd1234, 16'd0, 3,  3'd3, 4'd0);
        applyStimulus("unlock acc1",    0, 2'd2, 5'd1,  16'd0,    16'd0, 3,  3'd6, 4'd0);
        applyStimulus("auth after unl", 0, 2'd0, 5'd1,  16'd1234, 16'd0, 3,  3'd0, 4'd0);

        applyStimulus("pin same",       0, 2'd1, 5'd10, 16'd7123, 16'd7123, 12, 3'd5, 4'd9);
        applyStimulus("pin changed",    0, 2'd1, 5'd10, 16'd7123, 16'd4242, 12, 3'd4, 4'd9);
        applyStimulus("old pin bad",    0, 2'd0, 5'd10, 16'd7123, 16'd0,    12, 3'd2, 4'd9);
        applyStimulus("new pin ok",     0, 2'd0, 5'd10, 16'd4242, 16'd0,    12, 3'd0, 4'd9);

        // A cleared counter allows two more misses without lockout.
        applyStimulus("chg wrong pin",  0, 2'd1, 5'd2,  16'd9999, 16'd1111, 4, 3'd2, 4'd1);
        applyStimulus("acc2 pin kept",  0, 2'd0, 5'd2,  16'd2345, 16'd0,    4, 3'd0, 4'd1);
        applyStimulus("acc2 miss a",    0, 2'd0, 5'd2,  16'd1,    16'd0,    4, 3'd2, 4'd1);
        applyStimulus("acc2 miss b",    0, 2'd0, 5'd2,  16'd1,    16'd0,    4, 3'd2, 4'd1);
        applyStimulus("acc2 not lock",  0, 2'd0, 5'd2,  16'd2345, 16'd0,    4, 3'd0, 4'd1);

        // Reset during SEARCH of a CHANGE_PIN on account 5.
        @(negedge clk);
        req_op      = 2'd1;
        acc_num     = 5'd5;
        pin         = 16'd5678;
        new_pin     = 16'd1111;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midreset rsp_valid", rsp_valid_a, 0);
        checkOutput("midreset req_ready", req_ready_a, 1);
        seen_rsp = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid_a) seen_rsp = 1'b1;
        end
        checkOutput("midreset no response", seen_rsp, 0);
        applyStimulus("acc5 pin kept",  0, 2'd0, 5'd5,  16'd5678, 16'd0, 7,  3'd0, 4'd4);
        applyStimulus("acc10 restored", 0, 2'd0, 5'd10, 16'd7123, 16'd0, 12, 3'd0, 4'd9);

        applyStimulus("b auth acc16",   1, 2'd0, 5'd16, 16'd1015, 16'd0, 18, 3'd0, 4'd15);
        applyStimulus("b auth acc17",   1, 2'd0, 5'd17, 16'd1015, 16'd0, 17, 3'd1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
